// File: rtl/oka_subproduct_engine_64bit_pkg.sv
// oka_pkg: shared widths, FSM states and digit-size legality check for the OKA sub-product engine
package oka_pkg;
    localparam int OKA_N  = 64;
    localparam int OKA_H  = 32;
    localparam int OKA_PW = 63;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic bit legal_d(input int d);
        return d == 1 || d == 2 || d == 4 || d == 8 || d == 16 || d == 32;
    endfunction
endpackage

// File: rtl/oka_subproduct_engine_64bit_gf2_digit_mult.sv
// gf2_digit_mult: HxH digit-serial carry-less multiply-accumulate, MSB digit of bop first
module gf2_digit_mult #(
    parameter int H  = 32,
    parameter int D  = 1,
    parameter int CW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           step,
    input  logic [CW-1:0]  cnt,
    input  logic [H-1:0]   aop,
    input  logic [H-1:0]   bop,
    output logic [2*H-2:0] acc
);
    logic [D-1:0]   dig;
    logic [2*H-2:0] part;

    assign dig = D'(bop >> (H - D - int'(cnt) * D));

    // partial product of aop with the current D-bit digit of bop
    always_comb begin
        part = '0;
        for (int j = 0; j < D; j++)
            part = part ^ (dig[j] ? ({{(H - 1){1'b0}}, aop} << j) : '0);
    end

    // Horner accumulation: shift previous result up one digit, fold in the new partial
    always_ff @(posedge clk) begin
        if (!rst_n)
            acc <= '0;
        else if (start)
            acc <= '0;
        else if (step)
            acc <= (acc << D) ^ part;
    end
endmodule

// File: rtl/oka_subproduct_engine_64bit.sv
// oka_subproduct_engine_64bit: even/odd split and digit-serial P0, P2, M sub-products for OKA
module oka_subproduct_engine_64bit
    import oka_pkg::*;
#(
    parameter int N = 64,
    parameter int D = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OKA_PW-1:0] B2_in1,
    output logic [OKA_PW-1:0] B2_in2,
    output logic [OKA_PW-1:0] B2_in3,
    output logic [OKA_PW-1:0] B2_in4
);
    localparam int CW = (OKA_H / D > 1) ? $clog2(OKA_H / D) : 1;
    localparam logic [CW-1:0] LAST = CW'(OKA_H / D - 1);

    generate
        if (N != OKA_N || !legal_d(D)) begin : g_bad
            $error("oka_subproduct_engine_64bit: N must be 64 and D one of 1,2,4,8,16,32");
        end
    endgenerate

    state_t             state, nxt;
    logic [CW-1:0]      cnt;
    logic [OKA_H-1:0]   sae, sao, sbe, sbo;
    logic [OKA_H-1:0]   ae, ao, be, bo, am, bm;
    logic               accept, step;
    logic [OKA_PW-1:0]  acc_p0, acc_p2, acc_m;

    // even/odd coefficient split of both operands
    always_comb begin
        sae = '0;
        sao = '0;
        sbe = '0;
        sbo = '0;
        for (int i = 0; i < OKA_H; i++) begin
            sae[i] = a[2*i];
            sao[i] = a[2*i+1];
            sbe[i] = b[2*i];
            sbo[i] = b[2*i+1];
        end
    end

    assign accept = in_valid && in_ready;
    assign step   = state == BUSY;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    // next state and handshake outputs
    always_comb begin
        nxt       = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        if (state == IDLE && in_valid)
            nxt = BUSY;
        if (state == BUSY && cnt == LAST)
            nxt = DONE;
        if (state == DONE && out_ready)
            nxt = IDLE;
    end

    // operand latch on accept and digit counter during BUSY
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            ae  <= '0;
            ao  <= '0;
            be  <= '0;
            bo  <= '0;
            am  <= '0;
            bm  <= '0;
        end else if (accept) begin
            cnt <= '0;
            ae  <= sae;
            ao  <= sao;
            be  <= sbe;
            bo  <= sbo;
            am  <= sae ^ sao;
            bm  <= sbe ^ sbo;
        end else if (step) begin
            cnt <= cnt + CW'(1);
        end
    end

    gf2_digit_mult #(.H(OKA_H), .D(D), .CW(CW)) u_p0 (
        .clk(clk), .rst_n(rst_n), .start(accept), .step(step), .cnt(cnt),
        .aop(ae), .bop(be), .acc(acc_p0)
    );

    gf2_digit_mult #(.H(OKA_H), .D(D), .CW(CW)) u_p2 (
        .clk(clk), .rst_n(rst_n), .start(accept), .step(step), .cnt(cnt),
        .aop(ao), .bop(bo), .acc(acc_p2)
    );

    gf2_digit_mult #(.H(OKA_H), .D(D), .CW(CW)) u_m (
        .clk(clk), .rst_n(rst_n), .start(accept), .step(step), .cnt(cnt),
        .aop(am), .bop(bm), .acc(acc_m)
    );

    assign B2_in1 = acc_p0;
    assign B2_in2 = acc_m;
    assign B2_in3 = acc_p0 ^ acc_p2;
    assign B2_in4 = acc_p2;
endmodule
